alu_unit: RTL and testbench

//  32-bit integer ALU for the single-cycle/pipelined datapath execute stage.

---
 rtl/alu_unit.sv | 95 +++++++++
 tb/tb_alu_unit.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/alu_unit.sv
// 32-bit execute-stage ALU with a registered result and carry flag (one clock of latency).
// Optional signed-overflow output is enabled by defining ALU_OVERFLOW_EN.
module alu_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] Src1,
    input  logic [31:0] Src2,
    input  logic [5:0]  Funct,
`ifdef ALU_OVERFLOW_EN
    output logic        ALU_Overflow,
`endif
    output logic [31:0] ALU_result,
    output logic        ALU_Carry
);

    localparam logic [5:0] F_NOP  = 6'b000000;
    localparam logic [5:0] F_ADD  = 6'b000001;
    localparam logic [5:0] F_SUB  = 6'b000010;
    localparam logic [5:0] F_AND  = 6'b000011;
    localparam logic [5:0] F_OR   = 6'b000100;
    localparam logic [5:0] F_XOR  = 6'b000101;
    localparam logic [5:0] F_NOR  = 6'b000110;
    localparam logic [5:0] F_SLL  = 6'b000111;
    localparam logic [5:0] F_SRL  = 6'b001000;
    localparam logic [5:0] F_SRA  = 6'b001001;
    localparam logic [5:0] F_SLT  = 6'b001010;
    localparam logic [5:0] F_SLTU = 6'b001011;

    typedef struct packed {
        logic [31:0] result;
        logic        carry;
`ifdef ALU_OVERFLOW_EN
        logic        ovf;
`endif
    } alu_res_t;

    alu_res_t    res_d, res_q;
    logic [4:0]  sh;
    logic [32:0] sum, diff, sll_ext;
    logic [32:0] srl_ext, sra_ext;
    logic        slt, sltu;

    assign sh   = Src2[4:0];
    assign sum  = {1'b0, Src1} + {1'b0, Src2};
    assign diff = {1'b0, Src1} - {1'b0, Src2};

    // Widening by one bit lets the shifter itself deliver the last bit shifted
    // out; for sh=0 that extra bit is the zero padding, so carry is 0.
    assign sll_ext = {1'b0, Src1} << sh;
    assign srl_ext = {Src1, 1'b0} >> sh;
    assign sra_ext = $unsigned($signed({Src1, 1'b0}) >>> sh);

    assign slt  = $signed(Src1) < $signed(Src2);
    assign sltu = diff[32];

    always_comb begin
        res_d = '0;
        case (Funct)
            F_NOP: ;
            F_ADD: {res_d.carry, res_d.result} = sum;
            F_SUB: begin
                res_d.result = diff[31:0];
                res_d.carry  = ~diff[32];
            end
            F_AND: res_d.result = Src1 & Src2;
            F_OR:  res_d.result = Src1 | Src2;
            F_XOR: res_d.result = Src1 ^ Src2;
            F_NOR: res_d.result = ~(Src1 | Src2);
            F_SLL: {res_d.carry, res_d.result} = sll_ext;
            F_SRL: {res_d.result, res_d.carry} = srl_ext;
            F_SRA: {res_d.result, res_d.carry} = sra_ext;
            F_SLT:  res_d.result = {31'b0, slt};
            F_SLTU: res_d.result = {31'b0, sltu};
            default: ;
        endcase
`ifdef ALU_OVERFLOW_EN
        if (Funct == F_ADD)
            res_d.ovf = (Src1[31] == Src2[31]) && (sum[31] != Src1[31]);
        else if (Funct == F_SUB)
            res_d.ovf = (Src1[31] != Src2[31]) && (diff[31] != Src1[31]);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) res_q <= '0;
        else        res_q <= res_d;
    end

    assign ALU_result = res_q.result;
    assign ALU_Carry  = res_q.carry;
`ifdef ALU_OVERFLOW_EN
    assign ALU_Overflow = res_q.ovf;
`endif

endmodule

// File: tb/tb_alu_unit.sv
// Table-driven bench for alu_unit with an expected-result queue; covers reset,
// every opcode, shift/compare boundaries and a mid-operation reset.
module tb_alu_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] Src1, Src2;
    logic [5:0]  Funct;
    logic [31:0] ALU_result;
    logic        ALU_Carry;
`ifdef ALU_OVERFLOW_EN
    logic        ALU_Overflow;
`endif

    alu_unit dut (
        .clk(clk), .rst_n(rst_n), .Src1(Src1), .Src2(Src2), .Funct(Funct),
`ifdef ALU_OVERFLOW_EN
        .ALU_Overflow(ALU_Overflow),
`endif
        .ALU_result(ALU_result), .ALU_Carry(ALU_Carry)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic [31:0] a, b;
        logic [5:0]  f;
        logic [31:0] r;
        logic        c, v;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   passed = 0;
    int   total  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic drive(input vec_t v);
        Src1 = v.a; Src2 = v.b; Funct = v.f;
        sb.push_back(v);
    endtask

    task automatic sb_check();
        vec_t e;
        if (sb.size() == 0) begin
            total++;
            $display("FAIL scoreboard: got empty queue expected entry");
            return;
        end
        e = sb.pop_front();
        chk({e.nm, ".result"}, ALU_result, e.r);
        chk({e.nm, ".carry"}, {31'b0, ALU_Carry}, {31'b0, e.c});
`ifdef ALU_OVERFLOW_EN
        chk({e.nm, ".ovf"}, {31'b0, ALU_Overflow}, {31'b0, e.v});
`endif
    endtask

    initial begin
        vecs.push_back('{"add_c",     32'h0F0F0F1F, 32'hF0F0F0F0, 6'b000001, 32'h0000000F, 1'b1, 1'b0});
        vecs.push_back('{"add_nc",    32'h00000200, 32'h00001800, 6'b000001, 32'h00001A00, 1'b0, 1'b0});
        vecs.push_back('{"nop",       32'h00000200, 32'h00001800, 6'b000000, 32'h00000000, 1'b0, 1'b0});
        vecs.push_back('{"sub_brw",   32'h00000005, 32'h00000007, 6'b000010, 32'hFFFFFFFE, 1'b0, 1'b0});
        vecs.push_back('{"sub_pos",   32'h00000007, 32'h00000005, 6'b000010, 32'h00000002, 1'b1, 1'b0});
        vecs.push_back('{"sub_eq",    32'h00000005, 32'h00000005, 6'b000010, 32'h00000000, 1'b1, 1'b0});
        vecs.push_back('{"slt_t",     32'hFFFFFFFF, 32'h00000001, 6'b001010, 32'h00000001, 1'b0, 1'b0});
        vecs.push_back('{"sltu_f",    32'hFFFFFFFF, 32'h00000001, 6'b001011, 32'h00000000, 1'b0, 1'b0});
        vecs.push_back('{"slt_f",     32'h00000001, 32'hFFFFFFFF, 6'b001010, 32'h00000000, 1'b0, 1'b0});
        vecs.push_back('{"sltu_t",    32'h00000001, 32'hFFFFFFFF, 6'b001011, 32'h00000001, 1'b0, 1'b0});
        vecs.push_back('{"sll1",      32'h80000001, 32'h00000001, 6'b000111, 32'h00000002, 1'b1, 1'b0});
        vecs.push_back('{"srl1",      32'h80000001, 32'h00000001, 6'b001000, 32'h40000000, 1'b1, 1'b0});
        vecs.push_back('{"sra1",      32'h80000001, 32'h00000001, 6'b001001, 32'hC0000000, 1'b1, 1'b0});
        vecs.push_back('{"sll0_hi",   32'h80000001, 32'h00000020, 6'b000111, 32'h80000001, 1'b0, 1'b0});
        vecs.push_back('{"sra0",      32'h80000001, 32'h00000000, 6'b001001, 32'h80000001, 1'b0, 1'b0});
        vecs.push_back('{"srl31",     32'h80000001, 32'h0000001F, 6'b001000, 32'h00000001, 1'b0, 1'b0});
        vecs.push_back('{"sll31",     32'h00000003, 32'hFFFFFFFF, 6'b000111, 32'h80000000, 1'b1, 1'b0});
        vecs.push_back('{"sra4",      32'h80000000, 32'h00000004, 6'b001001, 32'hF8000000, 1'b0, 1'b0});
        vecs.push_back('{"srl4",      32'h0000001C, 32'h00000004, 6'b001000, 32'h00000001, 1'b1, 1'b0});
        vecs.push_back('{"and",       32'hFF00FF00, 32'h0F0F0F0F, 6'b000011, 32'h0F000F00, 1'b0, 1'b0});
        vecs.push_back('{"or",        32'hFF00FF00, 32'h0F0F0F0F, 6'b000100, 32'hFF0FFF0F, 1'b0, 1'b0});
        vecs.push_back('{"xor",       32'hFF00FF00, 32'h0F0F0F0F, 6'b000101, 32'hF00FF00F, 1'b0, 1'b0});
        vecs.push_back('{"nor",       32'hFF00FF00, 32'h0F0F0F0F, 6'b000110, 32'h00F000F0, 1'b0, 1'b0});
        vecs.push_back('{"add_ovf",   32'h7FFFFFFF, 32'h00000001, 6'b000001, 32'h80000000, 1'b0, 1'b1});
        vecs.push_back('{"add_ncovf", 32'h80000000, 32'h80000000, 6'b000001, 32'h00000000, 1'b1, 1'b1});
        vecs.push_back('{"add_wrap",  32'hFFFFFFFF, 32'h00000001, 6'b000001, 32'h00000000, 1'b1, 1'b0});
        vecs.push_back('{"sub_ovf",   32'h80000000, 32'h00000001, 6'b000010, 32'h7FFFFFFF, 1'b1, 1'b1});
        vecs.push_back('{"sub_novf",  32'h00000001, 32'h80000000, 6'b000010, 32'h80000001, 1'b0, 1'b1});
        vecs.push_back('{"undef3f",   32'hFFFFFFFF, 32'hFFFFFFFF, 6'b111111, 32'h00000000, 1'b0, 1'b0});
        vecs.push_back('{"undef0c",   32'h7FFFFFFF, 32'h00000001, 6'b001100, 32'h00000000, 1'b0, 1'b0});

        // Power-up reset asserted between edges, with live operands on the inputs
        rst_n = 1'b1;
        Src1 = 32'h0F0F0F1F; Src2 = 32'hF0F0F0F0; Funct = 6'b000001;
        @(posedge clk); #2;
        rst_n = 1'b0; #1;
        chk("reset_async.result", ALU_result, 32'h0);
        chk("reset_async.carry", {31'b0, ALU_Carry}, 32'h0);
        @(posedge clk); #1;
        chk("reset_hold.result", ALU_result, 32'h0);
        chk("reset_hold.carry", {31'b0, ALU_Carry}, 32'h0);
`ifdef ALU_OVERFLOW_EN
        chk("reset_hold.ovf", {31'b0, ALU_Overflow}, 32'h0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i]);
            @(posedge clk); #1;
            sb_check();
            @(negedge clk);
        end

        // Back-to-back ops: results must track one cycle behind the inputs
        drive(vecs[0]);
        @(posedge clk); #1;
        drive(vecs[3]);
        sb_check();
        @(posedge clk); #1;
        sb_check();
        @(negedge clk);

        // Reset mid-operation: pending SUB is discarded; first edge after release uses XOR
        drive(vecs[3]);
        void'(sb.pop_back());
        #1 rst_n = 1'b0; #1;
        chk("midrst.result", ALU_result, 32'h0);
        chk("midrst.carry", {31'b0, ALU_Carry}, 32'h0);
        @(posedge clk); #1;
        chk("midrst_hold.result", ALU_result, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(vecs[21]);
        @(posedge clk); #1;
        sb_check();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
